pwm_capture: RTL and testbench

Input-capture block that measures an external PWM waveform: period and high time, counted in prescaled clock ticks. It is the receive-side counterpart of the PWM generator's counter/prescaler path. It sits beside the generator in the peripheral and feeds the register file: captured values, a valid strobe and a sticky overflow flag.

---
 rtl/pwm_capture.sv | 123 ++++++++++++
 tb/tb_pwm_capture.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM input in prescaled clk ticks.
// Defining PWM_CAPTURE_IRQ_EN adds a sticky irq output with an irq_ack input.
module pwm_capture #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pwm_in,
    input  logic        en,
    input  logic        clear,
    input  logic [7:0]  prescale,
    output logic [15:0] period_out,
    output logic [15:0] high_out,
    output logic        valid,
    output logic        overflow,
    output logic [1:0]  state_out
`ifdef PWM_CAPTURE_IRQ_EN
    ,
    output logic        irq,
    input  logic        irq_ack
`endif
);
    typedef enum logic [1:0] {IDLE = 2'b00, ARM = 2'b01, HIGH = 2'b10, LOW = 2'b11} state_t;
    state_t state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic        prev, rise, fall, tick, sat_hit;
    logic [7:0]  presc_cnt;
    logic [15:0] timer, high_snap, cap;
    logic [16:0] sum;

    assign rise      = sync_q[SYNC_STAGES-1] & ~prev;
    assign fall      = ~sync_q[SYNC_STAGES-1] & prev;
    assign tick      = en && (presc_cnt == prescale);
    assign sum       = {1'b0, timer} + {16'd0, tick};
    assign cap       = sum[16] ? 16'hFFFF : sum[15:0];
    assign sat_hit   = tick && (timer == 16'hFFFF);
    assign state_out = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev   <= 1'b0;
        end else begin
            {prev, sync_q} <= {sync_q, pwm_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            presc_cnt  <= 8'd0;
            timer      <= 16'd0;
            high_snap  <= 16'd0;
            period_out <= 16'd0;
            high_out   <= 16'd0;
            valid      <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (clear) begin
                state      <= en ? ARM : IDLE;
                presc_cnt  <= 8'd0;
                timer      <= 16'd0;
                high_snap  <= 16'd0;
                period_out <= 16'd0;
                high_out   <= 16'd0;
                overflow   <= 1'b0;
            end else if (!en) begin
                state     <= IDLE;
                presc_cnt <= 8'd0;
                timer     <= 16'd0;
            end else begin
                presc_cnt <= tick ? 8'd0 : presc_cnt + 8'd1;
                timer     <= cap;
                case (state)
                    IDLE: begin
                        state     <= ARM;
                        presc_cnt <= 8'd0;
                        timer     <= 16'd0;
                    end
                    ARM: if (rise) begin
                        state     <= HIGH;
                        presc_cnt <= 8'd0;
                        timer     <= 16'd0;
                    end
                    HIGH: if (fall) begin
                        high_snap <= cap;
                        state     <= LOW;
                    end else if (sat_hit) begin
                        overflow <= 1'b1;
                        state    <= ARM;
                    end
                    LOW: if (rise) begin
                        period_out <= cap;
                        high_out   <= high_snap;
                        valid      <= 1'b1;
                        presc_cnt  <= 8'd0;
                        timer      <= 16'd0;
                        state      <= HIGH;
                    end else if (sat_hit) begin
                        overflow <= 1'b1;
                        state    <= ARM;
                    end
                endcase
            end
        end
    end

`ifdef PWM_CAPTURE_IRQ_EN
    logic ovf_d;

    // a new capture or a fresh overflow sets irq, and beats a same-cycle ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_d <= 1'b0;
            irq   <= 1'b0;
        end else begin
            ovf_d <= overflow;
            irq   <= valid | (overflow & ~ovf_d) | (irq & ~(irq_ack | clear));
        end
    end
`endif
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed test of pwm_capture with hand-computed expectations.
module tb_pwm_capture;
    logic        clk = 1'b0;
    logic        rst_n, pwm_in, en, clear;
    logic [7:0]  prescale;
    logic [15:0] period_out, high_out;
    logic        valid, overflow;
    logic [1:0]  state_out;
`ifdef PWM_CAPTURE_IRQ_EN
    logic        irq, irq_ack;
`endif

    int n_chk = 0, n_pass = 0;
    int cyc = 0, vcnt = 0, last_vcyc = 0;
    int exp_p = 0, exp_h = 0, exp_gap = 0;

    pwm_capture #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .en(en), .clear(clear),
        .prescale(prescale), .period_out(period_out), .high_out(high_out),
        .valid(valid), .overflow(overflow), .state_out(state_out)
`ifdef PWM_CAPTURE_IRQ_EN
        , .irq(irq), .irq_ack(irq_ack)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_pwm(input int per, input int hi, input int n);
        for (int i = 0; i < n; i++) begin
            pwm_in = 1'b1;
            repeat (hi) step();
            pwm_in = 1'b0;
            repeat (per - hi) step();
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    always @(negedge clk) begin
        if (valid) begin
            check("valid_period", period_out, exp_p);
            check("valid_high", high_out, exp_h);
            if (vcnt > 0) check("valid_gap", cyc - last_vcyc, exp_gap);
            last_vcyc = cyc;
            vcnt++;
        end
    end

`ifdef PWM_CAPTURE_IRQ_EN
    task automatic wait_valid();
        for (int i = 0; i < 100 && !valid; i++) step();
        check("valid_seen", valid, 1);
    endtask
`endif

    initial begin
        rst_n = 1'b0; pwm_in = 1'b0; en = 1'b0; clear = 1'b0; prescale = 8'd0;
`ifdef PWM_CAPTURE_IRQ_EN
        irq_ack = 1'b0;
`endif
        repeat (3) step();
        check("rst_period", period_out, 0);
        check("rst_high", high_out, 0);
        check("rst_valid", valid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_state", state_out, 0);
        rst_n = 1'b1;
        step();
        check("idle_no_en", state_out, 0);

        en = 1'b1;
        repeat (2) step();
        check("arm_after_en", state_out, 1);
        exp_p = 10; exp_h = 3; exp_gap = 10; vcnt = 0;
        run_pwm(10, 3, 1);
        check("no_valid_first_rise", vcnt, 0);
        run_pwm(10, 3, 1);
        check("valid_after_rise2", vcnt, 1);
        run_pwm(10, 3, 2);
        repeat (5) step();
        check("basic_count", vcnt, 3);
        check("basic_state_low", state_out, 3);

        prescale = 8'd3;
        pulse_clear();
        check("clear_period", period_out, 0);
        check("clear_high", high_out, 0);
        check("clear_state", state_out, 1);
        exp_p = 20; exp_h = 5; exp_gap = 80; vcnt = 0;
        run_pwm(80, 20, 3);
        check("presc_count", vcnt, 2);
        check("presc_period", period_out, 20);
        check("presc_high", high_out, 5);

        pwm_in = 1'b1;
        repeat (6) step();
        check("in_high", state_out, 2);
        check("presc_count3", vcnt, 3);
        en = 1'b0;
        step();
        check("en_drop_idle", state_out, 0);
        check("en_drop_period_hold", period_out, 20);
        check("en_drop_high_hold", high_out, 5);
        pwm_in = 1'b0;
        repeat (4) step();
        check("idle_stays", state_out, 0);
        prescale = 8'd0;
        en = 1'b1;
        repeat (2) step();
        check("reen_arm", state_out, 1);
        exp_p = 10; exp_h = 3; exp_gap = 10; vcnt = 0;
        run_pwm(10, 3, 1);
        check("reen_no_valid", vcnt, 0);
        run_pwm(10, 3, 1);
        check("reen_valid", vcnt, 1);
        check("reen_period", period_out, 10);
        check("low_before_rst", state_out, 3);

        rst_n = 1'b0;
        #1;
        check("async_rst_period", period_out, 0);
        check("async_rst_high", high_out, 0);
        check("async_rst_state", state_out, 0);
        check("async_rst_valid", valid, 0);
        step();
        rst_n = 1'b1;
        repeat (2) step();
        check("rst_release_arm", state_out, 1);

        vcnt = 0;
        run_pwm(10, 3, 2);
        pwm_in = 1'b1;
        repeat (65538) step();
        check("ovf_not_yet", overflow, 0);
        step();
        check("ovf_set", overflow, 1);
        check("ovf_state_arm", state_out, 1);
        check("ovf_period_hold", period_out, 10);
        check("ovf_high_hold", high_out, 3);
        check("ovf_valid_count", vcnt, 2);
        repeat (5) step();
        check("ovf_sticky", overflow, 1);
        pulse_clear();
        check("ovf_cleared", overflow, 0);
        check("ovf_clr_period", period_out, 0);
        check("ovf_clr_high", high_out, 0);
        pwm_in = 1'b0;
        repeat (4) step();

`ifdef PWM_CAPTURE_IRQ_EN
        check("irq_cleared", irq, 0);
        vcnt = 0;
        fork
            run_pwm(10, 3, 3);
            begin
                wait_valid();
                step();
                check("irq_set", irq, 1);
                wait_valid();
                irq_ack = 1'b1;
                step();
                irq_ack = 1'b0;
                check("irq_set_wins", irq, 1);
                step();
                irq_ack = 1'b1;
                step();
                irq_ack = 1'b0;
                check("irq_acked", irq, 0);
            end
        join
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
